// File: rtl/cu_pkg.sv
// Shared definitions for the control-unit sequencer.
//   - 3-bit state encodings (IDLE..FAULT), visible on the sequencer state port
//   - status-flag bit positions inside the NFLAGS-wide flag register
package cu_pkg;

    typedef logic [2:0] cu_state_t;

    localparam cu_state_t IDLE   = 3'd0;
    localparam cu_state_t FETCH  = 3'd1;
    localparam cu_state_t DECODE = 3'd2;
    localparam cu_state_t EXEC   = 3'd3;
    localparam cu_state_t MEM    = 3'd4;
    localparam cu_state_t WB     = 3'd5;
    localparam cu_state_t HALT   = 3'd6;
    localparam cu_state_t FAULT  = 3'd7;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/cu_sequencer_if.sv
// Handshake bundle between the sequencer and the fetch, decode, execute and
// bus-interface units.
//   master : sequencer side; drives chip-selects, fetch_address and ir_q
//   slave  : unit side; drives the ready strobes and the decoded fields
interface cu_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int IR_W   = 32,
    parameter int NFLAGS = 4
);
    logic              cs_fcu;
    logic [ADDR_W-1:0] fetch_address;
    logic              ready_fcu;
    logic [IR_W-1:0]   ir;
    logic [IR_W-1:0]   ir_q;

    logic              cs_dec;
    logic              ready_dec;
    logic              dec_mem;
    logic              dec_branch;
    logic [NFLAGS-1:0] dec_cond;
    logic              dec_setf;
    logic              dec_halt;
    logic [ADDR_W-1:0] dec_target;

    logic              cs_eu;
    logic              ready_eu;
    logic [NFLAGS-1:0] eu_flags;

    logic              cs_biu;
    logic              ready_bus;

    modport master (
        output cs_fcu, fetch_address, ir_q, cs_dec, cs_eu, cs_biu,
        input  ready_fcu, ir, ready_dec, dec_mem, dec_branch, dec_cond,
               dec_setf, dec_halt, dec_target, ready_eu, eu_flags, ready_bus
    );

    modport slave (
        input  cs_fcu, fetch_address, ir_q, cs_dec, cs_eu, cs_biu,
        output ready_fcu, ir, ready_dec, dec_mem, dec_branch, dec_cond,
               dec_setf, dec_halt, dec_target, ready_eu, eu_flags, ready_bus
    );
endinterface

// File: rtl/cu_watchdog.sv
// Per-phase watchdog for the sequencer.
//   clk, rst : clock and asynchronous active-high reset
//   clear    : restart the count (asserted on every state change)
//   enable   : a phase is waiting on its ready this cycle
//   expire   : this is the TIMEOUT-th waiting cycle and ready is still low
// TIMEOUT = 0 disables the trap entirely.
module cu_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // The count runs 0..TIMEOUT-1 inside a state, so the last waiting cycle
    // is the one where the count already sits at TIMEOUT-1.
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = (TIMEOUT != 0) && enable && (cnt == LAST);

endmodule

// File: rtl/cu_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXEC/MEM/WB state machine driving the
// unit chip-selects, with program counter, status flags, branch resolution,
// retired-instruction counter and a per-phase watchdog.
//   clk, reset : clock and asynchronous active-high reset
//   start      : leave IDLE or HALT and fetch at the current pc
//   units      : handshake bundle to the fetch/decode/execute/bus units
//   flags, pc  : status-flag register and program counter
//   state      : encoded state (see cu_pkg)
//   halted     : sitting in HALT
//   fault      : watchdog trap, held until reset
//   retired    : retired-instruction count (wraps)
//
// state  | meaning
// IDLE   | after reset, waiting for start
// FETCH  | cs_fcu high, waiting ready_fcu
// DECODE | cs_dec high, waiting ready_dec
// EXEC   | cs_eu high, waiting ready_eu
// MEM    | cs_biu high, waiting ready_bus
// WB     | one cycle: resolve branch, update pc, count retire
// HALT   | halt decoded; start re-fetches at the same pc
// FAULT  | a unit hung past TIMEOUT; only reset leaves
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int IR_W    = 32,
    parameter int NFLAGS  = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    cu_sequencer_if.master    units,
    output logic [NFLAGS-1:0] flags,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  retired
);
    cu_state_t state_q, state_nxt;

    logic cs_fcu_q, cs_dec_q, cs_eu_q, cs_biu_q;
    logic cs_fcu_d, cs_dec_d, cs_eu_d, cs_biu_d;

    logic [ADDR_W-1:0] pc_q;
    logic [NFLAGS-1:0] flags_q;
    logic [IR_W-1:0]   ir_q_r;
    logic [CNT_W-1:0]  retired_q;

    logic              d_mem, d_branch, d_setf;
    logic [NFLAGS-1:0] d_cond;
    logic [ADDR_W-1:0] d_target;

    logic phase_ready, phase_wait, wd_expire, taken;

    always_comb begin
        phase_ready = 1'b0;
        case (state_q)
            FETCH:   phase_ready = units.ready_fcu;
            DECODE:  phase_ready = units.ready_dec;
            EXEC:    phase_ready = units.ready_eu;
            MEM:     phase_ready = units.ready_bus;
            default: phase_ready = 1'b0;
        endcase
    end

    assign phase_wait = (state_q == FETCH || state_q == DECODE ||
                         state_q == EXEC  || state_q == MEM) && !phase_ready;

    cu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (reset),
        .clear  (state_nxt != state_q),
        .enable (phase_wait),
        .expire (wd_expire)
    );

    // Flags have already been written by this instruction's EXEC phase.
    assign taken = d_branch && ((d_cond == '0) || ((flags_q & d_cond) != '0));

    // State register; the chip-selects are registered alongside it so they
    // track the state exactly and fall with reset asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cs_fcu_q <= 1'b0;
            cs_dec_q <= 1'b0;
            cs_eu_q  <= 1'b0;
            cs_biu_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cs_fcu_q <= cs_fcu_d;
            cs_dec_q <= cs_dec_d;
            cs_eu_q  <= cs_eu_d;
            cs_biu_q <= cs_biu_d;
        end
    end

    // Next state. A ready in the expiring cycle completes the phase.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:   if (start) state_nxt = FETCH;
            FETCH: begin
                if (units.ready_fcu)   state_nxt = DECODE;
                else if (wd_expire)    state_nxt = FAULT;
            end
            DECODE: begin
                if (units.ready_dec)   state_nxt = units.dec_halt ? HALT : EXEC;
                else if (wd_expire)    state_nxt = FAULT;
            end
            EXEC: begin
                if (units.ready_eu)    state_nxt = d_mem ? MEM : WB;
                else if (wd_expire)    state_nxt = FAULT;
            end
            MEM: begin
                if (units.ready_bus)   state_nxt = WB;
                else if (wd_expire)    state_nxt = FAULT;
            end
            WB:     state_nxt = FETCH;
            HALT:   if (start) state_nxt = FETCH;
            FAULT:  state_nxt = FAULT;
            default: state_nxt = FAULT;
        endcase
    end

    // Output decode from the upcoming state; one-hot by construction.
    always_comb begin
        cs_fcu_d = 1'b0;
        cs_dec_d = 1'b0;
        cs_eu_d  = 1'b0;
        cs_biu_d = 1'b0;
        case (state_nxt)
            FETCH:   cs_fcu_d = 1'b1;
            DECODE:  cs_dec_d = 1'b1;
            EXEC:    cs_eu_d  = 1'b1;
            MEM:     cs_biu_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= '0;
            flags_q   <= '0;
            ir_q_r    <= '0;
            retired_q <= '0;
            d_mem     <= 1'b0;
            d_branch  <= 1'b0;
            d_setf    <= 1'b0;
            d_cond    <= '0;
            d_target  <= '0;
        end else begin
            case (state_q)
                FETCH: if (units.ready_fcu) ir_q_r <= units.ir;
                DECODE: if (units.ready_dec) begin
                    d_mem    <= units.dec_mem;
                    d_branch <= units.dec_branch;
                    d_setf   <= units.dec_setf;
                    d_cond   <= units.dec_cond;
                    d_target <= units.dec_target;
                end
                EXEC: if (units.ready_eu && d_setf) flags_q <= units.eu_flags;
                WB: begin
                    pc_q      <= taken ? d_target : pc_q + ADDR_W'(1);
                    retired_q <= retired_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign units.cs_fcu        = cs_fcu_q;
    assign units.cs_dec        = cs_dec_q;
    assign units.cs_eu         = cs_eu_q;
    assign units.cs_biu        = cs_biu_q;
    assign units.fetch_address = pc_q;
    assign units.ir_q          = ir_q_r;

    assign flags   = flags_q;
    assign pc      = pc_q;
    assign state   = state_q;
    assign halted  = (state_q == HALT);
    assign fault   = (state_q == FAULT);
    assign retired = retired_q;

endmodule

// File: tb/tb_cu_sequencer.sv
module tb_cu_sequencer;
    localparam int ADDR_W = 16;
    localparam int IR_W   = 32;
    localparam int NFLAGS = 4;
    localparam int TOUT   = 8;
    localparam int CNT_W  = 16;

    logic clk, reset, start;
    logic [NFLAGS-1:0] flags;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        state;
    logic              halted, fault;
    logic [CNT_W-1:0]  retired;

    cu_sequencer_if #(.ADDR_W(ADDR_W), .IR_W(IR_W), .NFLAGS(NFLAGS)) bus ();

    cu_sequencer #(
        .ADDR_W(ADDR_W), .IR_W(IR_W), .NFLAGS(NFLAGS), .TIMEOUT(TOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .units(bus),
        .flags(flags), .pc(pc), .state(state), .halted(halted),
        .fault(fault), .retired(retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int excl_viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if ($countones({bus.cs_fcu, bus.cs_dec, bus.cs_eu, bus.cs_biu}) > 1)
            excl_viol <= excl_viol + 1;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ret;
        logic [3:0]  flg;
    } exp_t;
    exp_t sb[$];

    logic [15:0] m_pc = '0;
    logic [15:0] m_ret = '0;
    logic [3:0]  m_flags = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cs_vec();
        return {bus.cs_biu, bus.cs_eu, bus.cs_dec, bus.cs_fcu};
    endfunction

    task automatic set_ready(input int p, input logic v);
        case (p)
            1: bus.ready_fcu = v;
            2: bus.ready_dec = v;
            3: bus.ready_eu  = v;
            default: bus.ready_bus = v;
        endcase
    endtask

    // Waits for phase p's chip-select, holds ready low for dly cycles, then
    // raises ready for one cycle. hi = cycles cs was seen high, oth = cycles
    // another cs was high meanwhile.
    task automatic do_phase(input int p, input int dly, output int hi, output int oth);
        logic [3:0] mine;
        int w = 0;
        mine = 4'b0001 << (p - 1);
        hi = 0;
        oth = 0;
        while (((cs_vec() & mine) == 4'b0) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("cs_rise_p%0d", p), {31'b0, (cs_vec() & mine) != 4'b0}, 1);
        chk($sformatf("state_p%0d", p), {29'b0, state}, p);
        for (int k = 0; k < dly; k++) begin
            if ((cs_vec() & mine) != 4'b0) hi++;
            if ((cs_vec() & ~mine) != 4'b0) oth++;
            @(negedge clk);
        end
        if ((cs_vec() & mine) != 4'b0) hi++;
        if ((cs_vec() & ~mine) != 4'b0) oth++;
        set_ready(p, 1'b1);
        @(negedge clk);
        set_ready(p, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] i_ir, input logic mem, input logic br,
                             input logic [3:0] cond, input logic setf, input logic [15:0] tgt,
                             input logic [3:0] ef, input int exec_dly, input int bus_dly,
                             output int cyc_used);
        int t0, hi, oth;
        logic taken;
        exp_t e;
        t0 = cyc;
        if (setf) m_flags = ef;
        taken = br && ((cond == 4'b0) || ((m_flags & cond) != 4'b0));
        m_pc  = taken ? tgt : m_pc + 16'd1;
        m_ret = m_ret + 16'd1;
        e.pc = m_pc; e.ret = m_ret; e.flg = m_flags;
        sb.push_back(e);

        bus.ir = i_ir;
        do_phase(1, 0, hi, oth);
        chk("ir_q", bus.ir_q, i_ir);
        bus.dec_mem = mem; bus.dec_branch = br; bus.dec_cond = cond;
        bus.dec_setf = setf; bus.dec_target = tgt; bus.dec_halt = 1'b0;
        do_phase(2, 0, hi, oth);
        bus.eu_flags = ef;
        do_phase(3, exec_dly, hi, oth);
        if (mem) begin
            do_phase(4, bus_dly, hi, oth);
            chk("biu_cycles", hi, bus_dly + 1);
            chk("biu_other_cs", oth, 0);
        end
        chk("state_wb", {29'b0, state}, 5);
        chk("wb_cs_low", {28'b0, cs_vec()}, 0);
        @(negedge clk);
        chk("state_refetch", {29'b0, state}, 1);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("pc", {16'b0, pc}, {16'b0, e.pc});
            chk("retired", {16'b0, retired}, {16'b0, e.ret});
            chk("flags", {28'b0, flags}, {28'b0, e.flg});
            chk("fetch_address", {16'b0, bus.fetch_address}, {16'b0, e.pc});
        end
        cyc_used = cyc - t0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int cu, hi, oth, n;
        reset = 1'b0; start = 1'b0;
        bus.ready_fcu = 0; bus.ready_dec = 0; bus.ready_eu = 0; bus.ready_bus = 0;
        bus.ir = '0; bus.dec_mem = 0; bus.dec_branch = 0; bus.dec_cond = '0;
        bus.dec_setf = 0; bus.dec_halt = 0; bus.dec_target = '0; bus.eu_flags = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_state", {29'b0, state}, 0);
        chk("rst_pc", {16'b0, pc}, 0);
        chk("rst_flags", {28'b0, flags}, 0);
        chk("rst_ir_q", bus.ir_q, 0);
        chk("rst_retired", {16'b0, retired}, 0);
        chk("rst_cs", {28'b0, cs_vec()}, 0);
        chk("rst_halted", {31'b0, halted}, 0);
        chk("rst_fault", {31'b0, fault}, 0);

        // straight line
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            run_instr(32'h1000_0000 + i, 0, 0, 4'b0, 0, 16'h0, 4'b0, 0, 0, cu);
            chk($sformatf("cycles_instr%0d", i), cu, 4);
        end
        chk("retired_3", {16'b0, retired}, 3);

        // conditional branch taken then not taken
        run_instr(32'hB000_0001, 0, 1, 4'b0010, 1, 16'h0040, 4'b0010, 0, 0, cu);
        chk("br_taken_pc", {16'b0, pc}, 32'h40);
        run_instr(32'hB000_0002, 0, 1, 4'b0010, 1, 16'h0080, 4'b0000, 0, 0, cu);
        chk("br_not_taken_pc", {16'b0, pc}, 32'h41);

        // memory phase with 5-cycle bus delay
        run_instr(32'hA000_0003, 1, 0, 4'b0, 0, 16'h0, 4'b0, 0, 5, cu);
        chk("mem_cycles", cu, 10);

        // halt and resume
        run_instr(32'hB000_0004, 0, 1, 4'b0000, 0, 16'h0007, 4'b0, 0, 0, cu);
        bus.ir = 32'hF000_0000;
        do_phase(1, 0, hi, oth);
        bus.dec_mem = 0; bus.dec_branch = 0; bus.dec_cond = '0; bus.dec_setf = 0;
        bus.dec_halt = 1'b1;
        do_phase(2, 0, hi, oth);
        bus.dec_halt = 1'b0;
        repeat (2) @(negedge clk);
        chk("halt_state", {29'b0, state}, 6);
        chk("halt_halted", {31'b0, halted}, 1);
        chk("halt_pc", {16'b0, pc}, 32'h7);
        chk("halt_retired", {16'b0, retired}, {16'b0, m_ret});
        chk("halt_cs", {28'b0, cs_vec()}, 0);
        pulse_start();
        chk("resume_state", {29'b0, state}, 1);
        chk("resume_fetch_address", {16'b0, bus.fetch_address}, 32'h7);
        chk("resume_halted", {31'b0, halted}, 0);
        run_instr(32'h1000_0007, 0, 0, 4'b0, 0, 16'h0, 4'b0, 0, 0, cu);

        // ready on the last watchdog cycle wins
        run_instr(32'h1000_0008, 0, 0, 4'b0, 0, 16'h0, 4'b0, TOUT - 1, 0, cu);
        chk("wd_edge_fault", {31'b0, fault}, 0);
        chk("wd_edge_cycles", cu, 4 + TOUT - 1);

        // watchdog expiry in EXEC
        bus.ir = 32'h1000_0009;
        do_phase(1, 0, hi, oth);
        do_phase(2, 0, hi, oth);
        n = 0;
        while (state == 3'd3 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("wd_exec_cycles", n, TOUT);
        chk("wd_state", {29'b0, state}, 7);
        chk("wd_fault", {31'b0, fault}, 1);
        chk("wd_cs", {28'b0, cs_vec()}, 0);
        pulse_start();
        @(negedge clk);
        chk("wd_start_ignored", {29'b0, state}, 7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("wd_reset_state", {29'b0, state}, 0);
        chk("wd_reset_fault", {31'b0, fault}, 0);
        m_pc = '0; m_ret = '0; m_flags = '0;
        sb.delete();

        // pc wrap, then async reset mid-FETCH
        pulse_start();
        run_instr(32'hB000_000A, 0, 1, 4'b0000, 0, 16'hFFFF, 4'b0, 0, 0, cu);
        chk("pc_ffff", {16'b0, pc}, 32'hFFFF);
        run_instr(32'h1000_000B, 0, 0, 4'b0, 0, 16'h0, 4'b0, 0, 0, cu);
        chk("pc_wrap", {16'b0, pc}, 0);
        chk("fetch_cs_before_reset", {31'b0, bus.cs_fcu}, 1);
        reset = 1'b1;
        #1;
        chk("async_cs_fcu", {31'b0, bus.cs_fcu}, 0);
        chk("async_state", {29'b0, state}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("cs_exclusive", excl_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
- Parametrised successor to the processor control unit.
- Replaces the hard-wired flag latch and cu2 handshake chain with one explicit FETCH/DECODE/EXEC/MEM/WB state machine that drives chip-selects to the fetch, decoder, execution and bus-interface units.
- Owns the program counter, an N-bit status-flag register, conditional-branch resolution and a per-phase watchdog that traps hung units.
- Sits at processor top level in place of the control unit / cu2 pair.

Parameters:
- ADDR_W, 16, program counter and fetch address width
- IR_W, 32, instruction register width
- NFLAGS, 4, status flags; bit0 carry, bit1 zero, bit2 negative, bit3 overflow (extra bits user-defined)
- TIMEOUT, 64, max cycles waiting for any ready; 0 disables watchdog
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE/HALT and begin fetching at current pc
- cs_fcu  out  1  fetch request
- fetch_address  out  ADDR_W  address presented with cs_fcu (equals pc)
- ready_fcu  in  1  fetch done; ir valid this cycle
- ir  in  IR_W  fetched instruction
- ir_q  out  IR_W  latched instruction to decoder/eu
- cs_dec  out  1  decode request
- ready_dec  in  1  decode done; dec_* valid this cycle
- dec_mem  in  1  instruction needs a bus phase
- dec_branch  in  1  instruction is a branch
- dec_cond  in  NFLAGS  branch flag mask; all-zero = unconditional
- dec_setf  in  1  instruction updates flags
- dec_halt  in  1  halt instruction
- dec_target  in  ADDR_W  branch target
- cs_eu  out  1  execute request
- ready_eu  in  1  execute done
- eu_flags  in  NFLAGS  flag results, valid with ready_eu
- cs_biu  out  1  bus transfer request
- ready_bus  in  1  bus transfer done
- flags  out  NFLAGS  status-flag register
- pc  out  ADDR_W  program counter
- state  out  3  encoded FSM state
- halted  out  1  in HALT
- fault  out  1  watchdog trap, sticky
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: state=IDLE; pc, flags, ir_q, retired, every cs_*, halted and fault all 0.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- IDLE: on start go to FETCH.
- Phase handshake, same rule in FETCH, DECODE, EXEC and MEM:
  - the phase's cs is a registered output, high from the first cycle in the state until the cycle after ready is sampled high;
  - a ready input that is not for the current phase is ignored;
  - ready may arrive in the first cs cycle, so minimum phase length is 1 cycle.
- FETCH: on ready_fcu, ir_q<=ir; go to DECODE.
- DECODE: on ready_dec, latch all dec_* fields internally.
  - dec_halt: go to HALT; pc is not advanced and retired is not incremented.
  - Otherwise go to EXEC.
- EXEC: on ready_eu, flags<=eu_flags if dec_setf. Next state is MEM if dec_mem, else WB.
- MEM: on ready_bus go to WB.
- WB, one cycle:
  - taken = dec_branch & (dec_cond==0 | (flags & dec_cond)!=0), evaluated on flags already updated by this instruction;
  - pc<=taken ? dec_target : pc+1, modulo 2^ADDR_W (0xFFFF wraps to 0);
  - retired<=retired+1, wrapping;
  - go to FETCH.
- HALT: halted=1. start returns to FETCH at the unchanged pc (the halt instruction is re-fetched; software branches past it). halted clears in that transition.
- Watchdog:
  - counter clears on every state entry and increments each cycle spent waiting in FETCH, DECODE, EXEC or MEM;
  - when it reaches TIMEOUT with ready still low, go to FAULT: fault=1, all cs low;
  - FAULT exits only on reset; start is ignored there;
  - TIMEOUT=0 disables the watchdog.
- ready arriving in the same cycle the counter hits TIMEOUT wins: the phase completes with no fault.
- Asynchronous reset mid-phase drops every cs in the same cycle; the units must tolerate an aborted request.
- cs_* are mutually exclusive at all times.

Decomposition:
- Shared package cu_pkg:
  - state encoding localparams (IDLE..FAULT);
  - flag bit indices FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3.
- One sub-module, cu_watchdog: TIMEOUT-parametrised counter with clear, enable and expire outputs.

Test Plan:
- Straight line: start at pc=0; every unit readies after 1 cycle; no mem, no branch. Expect sequence FETCH,DECODE,EXEC,WB; pc 0→1→2→3; retired=3 after three instructions; 4 cycles per instruction.
- Conditional branch: eu_flags=4'b0010 with dec_setf=1, dec_branch=1, dec_cond=4'b0010, target=0x0040 → pc=0x0040. Repeat with flags=4'b0000 → pc=old+1.
- Memory phase: dec_mem=1, ready_bus delayed 5 cycles → cs_biu high exactly 6 cycles and cs_eu low throughout; then WB.
- Halt and resume: dec_halt=1 at pc=0x0007 → halted=1, pc=0x0007, retired unchanged; start → FETCH with fetch_address=0x0007.
- Watchdog: TIMEOUT=8 and ready_eu held low → fault=1 at cycle 8 of EXEC, all cs=0, start ignored; reset clears. ready_eu arriving on cycle 8 → no fault.
- Wrap and reset: pc=0xFFFF, non-branch → pc=0x0000. Assert reset mid-FETCH → cs_fcu falls asynchronously, state=IDLE.
